// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: issues one memory request per load/store, stalls the
// pipeline until the access completes or times out, and returns registered load data.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid_in,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [31:0] i_addr_in,
    input  logic [31:0] i_wdata_in,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata_out,
    output logic        o_rdata_valid,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_timeout_err;
    logic        w_start;
    logic        w_busy;
    logic        w_limit;

    assign w_start = (r_state == StIdle) && i_valid_in && (i_is_load || i_is_store);
    assign w_busy  = (r_state == StBusy);
    assign w_limit = (r_cnt == LIMIT);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_next = StBusy;
            StBusy:  if (i_mem_ack || w_limit) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rdata_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            if (w_start) begin
                // Store wins when both flags are set.
                r_addr  <= i_addr_in;
                r_wdata <= i_wdata_in;
                r_we    <= i_is_store;
                r_cnt   <= '0;
            end
            if (w_busy) begin
                // Ack is checked first so an ack on the limit cycle completes normally.
                if (i_mem_ack) begin
                    if (!r_we) begin
                        r_rdata       <= i_mem_rdata;
                        r_rdata_valid <= 1'b1;
                    end
                end else if (w_limit) begin
                    r_rdata       <= '0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign o_mem_req     = w_busy;
    assign o_mem_we      = r_we && w_busy;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_wdata;
    assign o_stall       = !i_reset && (w_start || w_busy);
    assign o_rdata_out   = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): a per-cycle vector table plus
// hand-written reset-during-busy and back-to-back load sequences.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, valid_in, is_load, is_store, mem_ack;
    logic [31:0] addr_in, wdata_in, mem_rdata;
    logic        mem_req, mem_we, stall, rdata_valid, timeout_err;
    logic [31:0] mem_addr, mem_wdata, rdata_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid_in    (valid_in),
        .i_is_load     (is_load),
        .i_is_store    (is_store),
        .i_addr_in     (addr_in),
        .i_wdata_in    (wdata_in),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_stall       (stall),
        .o_rdata_out   (rdata_out),
        .o_rdata_valid (rdata_valid),
        .o_timeout_err (timeout_err)
    );

    // ctl = {mem_req, mem_we, stall, rdata_valid, timeout_err} during the row's cycle
    typedef struct {
        logic        rst, v, ld, st;
        logic [31:0] addr, wd;
        logic        ack;
        logic [31:0] rd;
        logic [4:0]  ctl;
        logic [31:0] maddr, mwd, rout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic ld, logic st, logic [31:0] a,
                                logic [31:0] wd, logic ack, logic [31:0] rd, logic [4:0] ctl,
                                logic [31:0] maddr, logic [31:0] mwd, logic [31:0] rout);
        vec_t t;
        t.rst = r; t.v = v; t.ld = ld; t.st = st; t.addr = a; t.wd = wd;
        t.ack = ack; t.rd = rd; t.ctl = ctl; t.maddr = maddr; t.mwd = mwd; t.rout = rout;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic ld, input logic st,
                         input logic [31:0] a, input logic [31:0] wd, input logic ack,
                         input logic [31:0] rd);
        rst = r; valid_in = v; is_load = ld; is_store = st;
        addr_in = a; wdata_in = wd; mem_ack = ack; mem_rdata = rd;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctl_now();
        return {27'd0, mem_req, mem_we, stall, rdata_valid, timeout_err};
    endfunction

    initial begin
        // Reset and idle behaviour
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h999, 'h777, 0, 0, 5'b00000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 'h55, 5'b00000, 0, 0, 0));
        // Load, ack on first BUSY cycle
        vecs.push_back(mk(0, 1, 1, 0, 'h100, 0, 0, 0, 5'b00100, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 'h100, 0, 1, 'hDEADBEEF, 5'b10100, 'h100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 'h100, 0, 'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 'h100, 0, 'hDEADBEEF));
        // Store, ack after 3 wait cycles (ack lands on the limit cycle)
        vecs.push_back(mk(0, 1, 0, 1, 'h200, 'h12345678, 0, 0, 5'b00100, 'h100, 0, 'hDEADBEEF));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 0, 1, 'h200, 'h12345678, 0, 0, 5'b11100, 'h200,
                              'h12345678, 'hDEADBEEF));
        vecs.push_back(mk(0, 1, 0, 1, 'h200, 'h12345678, 1, 'hAAAA5555, 5'b11100, 'h200,
                          'h12345678, 'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 'h200, 'h12345678, 'hDEADBEEF));
        // Load and store both set: treated as a store
        vecs.push_back(mk(0, 1, 1, 1, 'h300, 'h0BADF00D, 0, 0, 5'b00100, 'h200, 'h12345678,
                          'hDEADBEEF));
        vecs.push_back(mk(0, 1, 1, 1, 'h300, 'h0BADF00D, 1, 'h5A5A5A5A, 5'b11100, 'h300,
                          'h0BADF00D, 'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 'h300, 'h0BADF00D, 'hDEADBEEF));
        // Timeout: 4 BUSY cycles without ack
        vecs.push_back(mk(0, 1, 1, 0, 'h400, 0, 0, 0, 5'b00100, 'h300, 'h0BADF00D, 'hDEADBEEF));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 1, 0, 'h400, 0, 0, 0, 5'b10100, 'h400, 0, 'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 'h400, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 'h400, 0, 0));
        // Load ack on the timeout-limit cycle
        vecs.push_back(mk(0, 1, 1, 0, 'h500, 0, 0, 0, 5'b00100, 'h400, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 1, 0, 'h500, 0, 0, 0, 5'b10100, 'h500, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 'h500, 0, 1, 'hCAFEF00D, 5'b10100, 'h500, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 'h500, 0, 'hCAFEF00D));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 'h500, 0, 'hCAFEF00D));

        apply(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wd,
                  vecs[i].ack, vecs[i].rd);
            chk($sformatf("row%0d_ctl", i), ctl_now(), {27'd0, vecs[i].ctl});
            chk($sformatf("row%0d_mem_addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vecs[i].mwd);
            chk($sformatf("row%0d_rdata_out", i), rdata_out, vecs[i].rout);
            step();
        end

        // Reset on the second BUSY cycle, then a fresh load
        apply(0, 1, 1, 0, 'h600, 'hFFFF0000, 0, 0);
        chk("rst_seq_start_stall", {31'd0, stall}, 32'd1);
        step();
        apply(0, 1, 1, 0, 'h600, 'hFFFF0000, 0, 0);
        chk("rst_seq_busy1_ctl", ctl_now(), 32'b10100);
        chk("rst_seq_busy1_addr", mem_addr, 32'h600);
        step();
        apply(1, 1, 1, 0, 'h600, 'hFFFF0000, 0, 0);
        chk("rst_seq_busy2_stall_in_reset", {31'd0, stall}, 32'd0);
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_seq_after_ctl", ctl_now(), 32'd0);
        chk("rst_seq_after_addr", mem_addr, 32'd0);
        chk("rst_seq_after_wdata", mem_wdata, 32'd0);
        chk("rst_seq_after_rdata", rdata_out, 32'd0);
        step();
        apply(0, 1, 1, 0, 'h700, 0, 0, 0);
        step();
        apply(0, 1, 1, 0, 'h700, 0, 1, 'h13579BDF);
        chk("post_rst_busy_ctl", ctl_now(), 32'b10100);
        chk("post_rst_busy_addr", mem_addr, 32'h700);
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_done_ctl", ctl_now(), 32'b00010);
        chk("post_rst_done_rdata", rdata_out, 32'h13579BDF);
        step();

        // Back-to-back loads with valid_in held high
        apply(0, 1, 1, 0, 'h800, 0, 0, 0);
        chk("b2b_start1_stall", {31'd0, stall}, 32'd1);
        step();
        apply(0, 1, 1, 0, 'h800, 0, 1, 'h11111111);
        chk("b2b_busy1_addr", mem_addr, 32'h800);
        step();
        apply(0, 1, 1, 0, 'h804, 0, 0, 0);
        chk("b2b_done1_ctl", ctl_now(), 32'b00010);
        chk("b2b_done1_rdata", rdata_out, 32'h11111111);
        step();
        apply(0, 1, 1, 0, 'h804, 0, 0, 0);
        chk("b2b_start2_ctl", ctl_now(), 32'b00100);
        step();
        apply(0, 1, 1, 0, 'h804, 0, 1, 'h22222222);
        chk("b2b_busy2_ctl", ctl_now(), 32'b10100);
        chk("b2b_busy2_addr", mem_addr, 32'h804);
        step();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_done2_ctl", ctl_now(), 32'b00010);
        chk("b2b_done2_rdata", rdata_out, 32'h22222222);
        step();
        chk("b2b_idle_ctl", ctl_now(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
